// File: rtl/flow_ctrl_pkg.sv
// Shared definitions for the program-flow controller: bus port codes,
// core state encoding and instruction-regfile mode encodings.
package flow_ctrl_pkg;

  // Port codes within the controller device
  localparam int unsigned PORT_JUMP_LARGER  = 1;
  localparam int unsigned PORT_JUMP_SMALLER = 2;
  localparam int unsigned PORT_JUMP_EQUAL   = 3;
  localparam int unsigned PORT_JUMP_UNEQUAL = 4;
  localparam int unsigned PORT_JUMP_DIRECT  = 5;
  localparam int unsigned PORT_JUMP_ADDR    = 6;
  localparam int unsigned PORT_WAIT         = 7;
  localparam int unsigned PORT_STOP         = 8;

  // Core state
  typedef enum logic [1:0] {
    ST_RST  = 2'd0,
    ST_WORK = 2'd1,
    ST_WAIT = 2'd2,
    ST_STOP = 2'd3
  } state_e;

  // Instruction regfile mode
  localparam logic [1:0] REGF_IDLE = 2'b00;
  localparam logic [1:0] REGF_RST  = 2'b01;
  localparam logic [1:0] REGF_WORK = 2'b10;

endpackage

// File: rtl/flow_wait_counter.sv
// Wait-stall down-counter.
// Ports: clk, rst (async active-high), load_i/load_val_i load a count,
// last_o is high while the count equals 1 (final stall cycle).
module flow_wait_counter #(
  parameter int unsigned WAIT_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic [WAIT_WIDTH-1:0] load_val_i,
  output logic                  last_o
);

  logic [WAIT_WIDTH-1:0] count_q, count_d;

  // Load has priority; otherwise count down and rest at zero
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - WAIT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign last_o = (count_q == WAIT_WIDTH'(1));

endmodule

// File: rtl/flow_controller.sv
// Program-flow controller: decodes bus writes to its device, owns the
// instruction pointer, and sequences the RST/WORK/WAIT/STOP core state.
// Ports: clk, rst (async active-high); bus write i_valid/i_device/i_address/
// i_data; ALU flags i_flags {larger,smaller,equal}; fetch i_advance.
// Outputs (all from registered state): o_ir_regfile_en, o_ir_pointer,
// o_stall, o_halted, o_jump_taken.
module flow_controller
  import flow_ctrl_pkg::*;
#(
  parameter int unsigned            DATA_WIDTH = 16,
  parameter int unsigned            PTR_WIDTH  = 16,
  parameter int unsigned            WAIT_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0]  DEVICE_ID  = DATA_WIDTH'(16'h0001),
  parameter logic [PTR_WIDTH-1:0]   RESET_PTR  = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_device,
  input  logic [DATA_WIDTH-1:0] i_address,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [2:0]            i_flags,
  input  logic                  i_advance,
  output logic [1:0]            o_ir_regfile_en,
  output logic [PTR_WIDTH-1:0]  o_ir_pointer,
  output logic                  o_stall,
  output logic                  o_halted,
  output logic                  o_jump_taken
);

  state_e                 state_q, state_d;
  logic [PTR_WIDTH-1:0]   ptr_q, ptr_d;
  logic [PTR_WIDTH-1:0]   tgt_q, tgt_d;
  logic                   jump_q, jump_d;
  logic                   wait_load;
  logic                   wait_last;
  logic                   take_jump;

  logic                   cmd;
  logic                   op_larger, op_smaller, op_equal, op_unequal;
  logic                   op_direct, op_addr, op_wait, op_stop;
  logic                   cond_hit;
  logic [WAIT_WIDTH-1:0]  wait_n;

  // Command decode
  assign cmd        = i_valid && (i_device == DEVICE_ID);
  assign op_larger  = (i_address == DATA_WIDTH'(PORT_JUMP_LARGER));
  assign op_smaller = (i_address == DATA_WIDTH'(PORT_JUMP_SMALLER));
  assign op_equal   = (i_address == DATA_WIDTH'(PORT_JUMP_EQUAL));
  assign op_unequal = (i_address == DATA_WIDTH'(PORT_JUMP_UNEQUAL));
  assign op_direct  = (i_address == DATA_WIDTH'(PORT_JUMP_DIRECT));
  assign op_addr    = (i_address == DATA_WIDTH'(PORT_JUMP_ADDR));
  assign op_wait    = (i_address == DATA_WIDTH'(PORT_WAIT));
  assign op_stop    = (i_address == DATA_WIDTH'(PORT_STOP));
  assign wait_n     = i_data[WAIT_WIDTH-1:0];

  // Flags are {larger, smaller, equal}
  assign cond_hit = (op_larger  &&  i_flags[2]) ||
                    (op_smaller &&  i_flags[1]) ||
                    (op_equal   &&  i_flags[0]) ||
                    (op_unequal && !i_flags[0]);

  // Next-state, pointer and target logic
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    tgt_d     = tgt_q;
    jump_d    = 1'b0;
    wait_load = 1'b0;
    take_jump = 1'b0;
    case (state_q)
      ST_RST: begin
        if (cmd && op_addr) tgt_d = i_data[PTR_WIDTH-1:0];
        if (cmd && op_direct) begin
          take_jump = 1'b1;
          state_d   = ST_WORK;
        end
      end
      ST_WORK: begin
        if (i_advance) ptr_d = ptr_q + PTR_WIDTH'(1);
        if (cmd) begin
          if (op_addr) tgt_d = i_data[PTR_WIDTH-1:0];
          if (op_direct || cond_hit) take_jump = 1'b1;
          if (op_wait && (wait_n != '0)) begin
            state_d   = ST_WAIT;
            wait_load = 1'b1;
          end
          if (op_stop) state_d = ST_STOP;
        end
      end
      ST_WAIT: begin
        if (wait_last) state_d = ST_WORK;
      end
      ST_STOP: begin
        if (cmd && op_direct) begin
          take_jump = 1'b1;
          state_d   = ST_WORK;
        end
      end
      default: state_d = ST_RST;
    endcase
    // A taken jump overrides any same-cycle advance
    if (take_jump) begin
      ptr_d  = tgt_q;
      jump_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RST;
      ptr_q   <= RESET_PTR;
      tgt_q   <= '0;
      jump_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      tgt_q   <= tgt_d;
      jump_q  <= jump_d;
    end
  end

  flow_wait_counter #(
    .WAIT_WIDTH (WAIT_WIDTH)
  ) u_wait_counter (
    .clk        (clk),
    .rst        (rst),
    .load_i     (wait_load),
    .load_val_i (wait_n),
    .last_o     (wait_last)
  );

  // Outputs decoded from registered state only
  always_comb begin
    o_ir_regfile_en = REGF_IDLE;
    case (state_q)
      ST_RST:  o_ir_regfile_en = REGF_RST;
      ST_WORK: o_ir_regfile_en = REGF_WORK;
      default: o_ir_regfile_en = REGF_IDLE;
    endcase
  end

  assign o_ir_pointer = ptr_q;
  assign o_stall      = (state_q == ST_WAIT);
  assign o_halted     = (state_q == ST_STOP);
  assign o_jump_taken = jump_q;

endmodule

// File: tb/tb_flow_controller.sv
// Directed bench for flow_controller with a queue-based scoreboard.
module tb_flow_controller;

  localparam logic [15:0] P_LG  = 16'd1;
  localparam logic [15:0] P_SM  = 16'd2;
  localparam logic [15:0] P_EQ  = 16'd3;
  localparam logic [15:0] P_NE  = 16'd4;
  localparam logic [15:0] P_DIR = 16'd5;
  localparam logic [15:0] P_ADR = 16'd6;
  localparam logic [15:0] P_WT  = 16'd7;
  localparam logic [15:0] P_STP = 16'd8;
  localparam logic [15:0] DEV   = 16'h0001;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic [15:0] i_device, i_address, i_data;
  logic [2:0]  i_flags;
  logic        i_advance;
  logic [1:0]  o_ir_regfile_en;
  logic [15:0] o_ir_pointer;
  logic        o_stall, o_halted, o_jump_taken;

  typedef struct {
    string       tag;
    logic [15:0] ptr;
    logic [1:0]  en;
    logic        st;
    logic        h;
    logic        jt;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  flow_controller dut (
    .clk             (clk),
    .rst             (rst),
    .i_valid         (i_valid),
    .i_device        (i_device),
    .i_address       (i_address),
    .i_data          (i_data),
    .i_flags         (i_flags),
    .i_advance       (i_advance),
    .o_ir_regfile_en (o_ir_regfile_en),
    .o_ir_pointer    (o_ir_pointer),
    .o_stall         (o_stall),
    .o_halted        (o_halted),
    .o_jump_taken    (o_jump_taken)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic push_exp(input string tag, input logic [15:0] ep, input logic [1:0] ee,
                          input logic es, input logic eh, input logic ej);
    exp_t e;
    e.tag = tag; e.ptr = ep; e.en = ee; e.st = es; e.h = eh; e.jt = ej;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    total++;
    assert (sb.size() != 0) else begin
      bad++;
      $error("FAIL sb_empty: observed size=0 expected size>0");
    end
    if (sb.size() == 0) return;
    e = sb.pop_front();
    assert (o_ir_pointer === e.ptr) else begin
      bad++; $error("FAIL %s ptr: observed=%h expected=%h", e.tag, o_ir_pointer, e.ptr);
    end
    total++;
    assert (o_ir_regfile_en === e.en) else begin
      bad++; $error("FAIL %s regfile_en: observed=%b expected=%b", e.tag, o_ir_regfile_en, e.en);
    end
    total++;
    assert (o_stall === e.st) else begin
      bad++; $error("FAIL %s stall: observed=%b expected=%b", e.tag, o_stall, e.st);
    end
    total++;
    assert (o_halted === e.h) else begin
      bad++; $error("FAIL %s halted: observed=%b expected=%b", e.tag, o_halted, e.h);
    end
    total++;
    assert (o_jump_taken === e.jt) else begin
      bad++; $error("FAIL %s jump_taken: observed=%b expected=%b", e.tag, o_jump_taken, e.jt);
    end
  endtask

  // Drive one cycle of bus/fetch inputs, then check the registered result.
  task automatic step(input string tag, input logic v, input logic [15:0] dev,
                      input logic [15:0] addr, input logic [15:0] data,
                      input logic [2:0] fl, input logic adv,
                      input logic [15:0] ep, input logic [1:0] ee,
                      input logic es, input logic eh, input logic ej);
    i_valid = v; i_device = dev; i_address = addr; i_data = data;
    i_flags = fl; i_advance = adv;
    push_exp(tag, ep, ee, es, eh, ej);
    @(posedge clk);
    #1;
    pop_check();
  endtask

  task automatic idle(input string tag, input logic [15:0] ep, input logic [1:0] ee,
                      input logic es, input logic eh, input logic ej);
    step(tag, 1'b0, DEV, 16'd0, 16'd0, 3'b000, 1'b0, ep, ee, es, eh, ej);
  endtask

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_device = '0; i_address = '0; i_data = '0;
    i_flags = '0; i_advance = 1'b0;
    #2;
    push_exp("reset", 16'h0000, 2'b01, 1'b0, 1'b0, 1'b0);
    pop_check();
    @(negedge clk);
    rst = 1'b0;

    // Boot: ADDR is latched, advance ignored in RST, DIRECT enters WORK
    step("boot_addr", 1, DEV, P_ADR, 16'h0040, 3'b000, 1, 16'h0000, 2'b01, 0, 0, 0);
    idle("boot_idle", 16'h0000, 2'b01, 0, 0, 0);
    step("boot_dir",  1, DEV, P_DIR, 16'h0000, 3'b000, 0, 16'h0040, 2'b10, 0, 0, 1);
    idle("boot_pulse_end", 16'h0040, 2'b10, 0, 0, 0);

    // Conditional jumps
    step("set_t10",   1, DEV, P_ADR, 16'h0010, 3'b000, 0, 16'h0040, 2'b10, 0, 0, 0);
    step("dir_10",    1, DEV, P_DIR, 16'h0000, 3'b000, 0, 16'h0010, 2'b10, 0, 0, 1);
    step("set_t100",  1, DEV, P_ADR, 16'h0100, 3'b000, 0, 16'h0010, 2'b10, 0, 0, 0);
    step("lg_miss",   1, DEV, P_LG,  16'h0000, 3'b010, 0, 16'h0010, 2'b10, 0, 0, 0);
    step("eq_hit",    1, DEV, P_EQ,  16'h0000, 3'b001, 0, 16'h0100, 2'b10, 0, 0, 1);
    step("adv_101",   0, DEV, 16'd0, 16'h0000, 3'b000, 1, 16'h0101, 2'b10, 0, 0, 0);
    step("ne_hit",    1, DEV, P_NE,  16'h0000, 3'b100, 0, 16'h0100, 2'b10, 0, 0, 1);
    step("sm_miss",   1, DEV, P_SM,  16'h0000, 3'b100, 1, 16'h0101, 2'b10, 0, 0, 0);
    step("sm_hit",    1, DEV, P_SM,  16'h0000, 3'b010, 0, 16'h0100, 2'b10, 0, 0, 1);
    step("lg_hit_adv",1, DEV, P_LG,  16'h0000, 3'b100, 1, 16'h0100, 2'b10, 0, 0, 1);

    // Jump vs advance, and ADDR + advance
    step("adv_101b",  0, DEV, 16'd0, 16'h0000, 3'b000, 1, 16'h0101, 2'b10, 0, 0, 0);
    step("dir_adv",   1, DEV, P_DIR, 16'h0000, 3'b000, 1, 16'h0100, 2'b10, 0, 0, 1);
    step("addr_adv",  1, DEV, P_ADR, 16'h0200, 3'b000, 1, 16'h0101, 2'b10, 0, 0, 0);
    step("dir_200",   1, DEV, P_DIR, 16'h0000, 3'b000, 0, 16'h0200, 2'b10, 0, 0, 1);

    // Wait 3: stall exactly 3 cycles, commands and advance ignored
    step("wait3_c1",  1, DEV, P_WT,  16'h0003, 3'b000, 0, 16'h0200, 2'b00, 1, 0, 0);
    step("wait3_c2",  1, DEV, P_DIR, 16'h0000, 3'b000, 1, 16'h0200, 2'b00, 1, 0, 0);
    step("wait3_c3",  0, DEV, 16'd0, 16'h0000, 3'b000, 1, 16'h0200, 2'b00, 1, 0, 0);
    idle("wait3_done", 16'h0200, 2'b10, 0, 0, 0);
    step("adv_201",   0, DEV, 16'd0, 16'h0000, 3'b000, 1, 16'h0201, 2'b10, 0, 0, 0);
    step("wait0",     1, DEV, P_WT,  16'h0000, 3'b000, 0, 16'h0201, 2'b10, 0, 0, 0);

    // Stop / resume
    step("stop",      1, DEV, P_STP, 16'h0000, 3'b000, 0, 16'h0201, 2'b00, 0, 1, 0);
    step("stop_adv",  0, DEV, 16'd0, 16'h0000, 3'b000, 1, 16'h0201, 2'b00, 0, 1, 0);
    step("stop_addr", 1, DEV, P_ADR, 16'h0300, 3'b000, 1, 16'h0201, 2'b00, 0, 1, 0);
    step("stop_eq",   1, DEV, P_EQ,  16'h0000, 3'b001, 0, 16'h0201, 2'b00, 0, 1, 0);
    step("resume",    1, DEV, P_DIR, 16'h0000, 3'b000, 0, 16'h0200, 2'b10, 0, 0, 1);

    // Wrong device, invalid strobe, unknown port: no effect
    step("dev2_addr", 1, 16'h0002, P_ADR, 16'h0050, 3'b000, 1, 16'h0201, 2'b10, 0, 0, 0);
    step("dev2_dir",  1, 16'h0002, P_DIR, 16'h0000, 3'b000, 0, 16'h0201, 2'b10, 0, 0, 0);
    step("novalid",   0, DEV, P_DIR, 16'h0000, 3'b000, 0, 16'h0201, 2'b10, 0, 0, 0);
    step("bad_port",  1, DEV, 16'd9, 16'h0000, 3'b000, 0, 16'h0201, 2'b10, 0, 0, 0);
    step("dir_chk",   1, DEV, P_DIR, 16'h0000, 3'b000, 0, 16'h0200, 2'b10, 0, 0, 1);

    // Pointer wrap
    step("set_ffff",  1, DEV, P_ADR, 16'hFFFF, 3'b000, 0, 16'h0200, 2'b10, 0, 0, 0);
    step("dir_ffff",  1, DEV, P_DIR, 16'h0000, 3'b000, 0, 16'hFFFF, 2'b10, 0, 0, 1);
    step("wrap",      0, DEV, 16'd0, 16'h0000, 3'b000, 1, 16'h0000, 2'b10, 0, 0, 0);

    // Async reset in WAIT
    step("wait5",     1, DEV, P_WT,  16'h0005, 3'b000, 0, 16'h0000, 2'b00, 1, 0, 0);
    step("wait5_c2",  0, DEV, 16'd0, 16'h0000, 3'b000, 1, 16'h0000, 2'b00, 1, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    push_exp("async_rst", 16'h0000, 2'b01, 1'b0, 1'b0, 1'b0);
    pop_check();
    @(negedge clk);
    rst = 1'b0;
    idle("post_rst", 16'h0000, 2'b01, 0, 0, 0);
    step("post_rst_dir", 1, DEV, P_DIR, 16'h0000, 3'b000, 0, 16'h0000, 2'b10, 0, 0, 1);
    step("post_rst_adv", 0, DEV, 16'd0, 16'h0000, 3'b000, 1, 16'h0001, 2'b10, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/flow_controller.md
# flow_controller

Parametrised program-flow controller for the core: the successor to the fixed single-width controller. Decodes writes addressed to the controller device on the core bus and owns the instruction pointer. Implements the RST/WORK core state and adds conditional jumps on ALU flags, a latched jump target, timed wait stalls and a sticky stop. Sits between the bus decode and the instruction regfile/fetch logic.

## Interface

**Parameters**
- `DATA_WIDTH`, default 16: bus data/address width.
- `PTR_WIDTH`, default 16: instruction pointer width (≤ `DATA_WIDTH`).
- `WAIT_WIDTH`, default 8: wait counter width (≤ `DATA_WIDTH`).
- `DEVICE_ID`, default 16'h0001: device code that selects this block.
- `RESET_PTR`, default 0: pointer value after reset.

**Ports**
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `i_valid`, input, 1: bus write strobe.
- `i_device`, input, `DATA_WIDTH`: target device code.
- `i_address`, input, `DATA_WIDTH`: port code within the device.
- `i_data`, input, `DATA_WIDTH`: jump target or wait count.
- `i_flags`, input, 3: ALU flags {larger, smaller, equal}.
- `i_advance`, input, 1: fetch consumed; increment pointer.
- `o_ir_regfile_en`, output, 2: regfile mode: 01 = reset, 10 = work, 00 = idle.
- `o_ir_pointer`, output, `PTR_WIDTH`: current instruction pointer (registered).
- `o_stall`, output, 1: high while in WAIT.
- `o_halted`, output, 1: high while in STOP.
- `o_jump_taken`, output, 1: one-cycle pulse after a pointer load.

## Operation

- **Command** = `i_valid` && `i_device`==`DEVICE_ID`. It is sampled at the rising edge. Non-commands have no effect.
- **Port codes**: JUMP_LARGER 1, JUMP_SMALLER 2, JUMP_EQUAL 3, JUMP_UNEQUAL 4, JUMP_DIRECT 5, JUMP_ADDR 6, WAIT 7, STOP 8. Any other code is ignored.
- **JUMP_ADDR** loads target register ← `i_data[PTR_WIDTH-1:0]`. It is accepted in RST and WORK.
- **Conditional jumps** load the pointer from the target register when the condition holds, else behave as a non-command:
  - JUMP_LARGER: `larger`.
  - JUMP_SMALLER: `smaller`.
  - JUMP_EQUAL: `equal`.
  - JUMP_UNEQUAL: `!equal`.
- **JUMP_DIRECT** loads the pointer from the target register unconditionally.
- **States**: RST, WORK, WAIT, STOP.
  - **RST**: only JUMP_ADDR and JUMP_DIRECT are honoured. JUMP_DIRECT loads the pointer and moves to WORK.
  - **WORK**: all commands are honoured. WAIT with count `i_data[WAIT_WIDTH-1:0]`=N>0 moves to WAIT with counter←N. N=0 stays in WORK. STOP moves to STOP.
  - **WAIT**: counter decrements each cycle. At counter==1 the next state is WORK. All commands and `i_advance` are ignored.
  - **STOP**: pointer frozen. Only JUMP_DIRECT is honoured: it loads the pointer and moves to WORK.
- **Pointer increment**: +1 on `i_advance` in WORK only. Wraps from all-ones to 0.
- **Jump vs. advance in the same cycle**: a taken jump wins, and the pointer equals the target (no +1).
- **JUMP_ADDR + `i_advance` in the same cycle**: the target is written and the pointer increments.
- **Outputs by state**:
  - `o_ir_regfile_en`: 01 in RST, 10 in WORK, 00 in WAIT and STOP.
  - `o_stall` = (state==WAIT).
  - `o_halted` = (state==STOP).

## Timing

- **Reset** (async assert; deassertion is synchronised by the system):
  - state RST, `o_ir_pointer`=`RESET_PTR`, target 0, counter 0.
  - `o_ir_regfile_en`=01, `o_stall`=0, `o_halted`=0, `o_jump_taken`=0.
- **Reset mid-operation**: all of the above apply immediately, from any state.
- **Jump latency**: a jump command at edge k gives `o_ir_pointer`=target and `o_jump_taken`=1 during cycle k+1. `o_jump_taken` clears at k+2 unless another jump is taken.
- **Wait**: a WAIT N command at edge k gives `o_stall` high for exactly N cycles (k+1..k+N) and WORK from k+N+1.
- **Stop**: `o_halted` rises the cycle after the STOP command.
- **Output registration**: all outputs are registered or decoded from registered state only. There is no combinational path from inputs to outputs.

## Structure

- **Package `flow_ctrl_pkg`**: port codes, state encoding (RST 0, WORK 1, WAIT 2, STOP 3), regfile-enable encodings (IDLE 00, RST 01, WORK 10).
- **Sub-module `flow_wait_counter`**, parametrised by `WAIT_WIDTH`: load/decrement with a `last` output. It is instantiated once.
- **Top**: command decode, state register, pointer/target registers.

## Test plan

- **Boot**: reset, ADDR 0x0040, then DIRECT.
  - Pointer stays 0 and regfile_en stays 01 until DIRECT.
  - Next cycle: pointer 0x0040, regfile_en 10, jump_taken pulse of 1 cycle.
- **Conditional jumps**: in WORK, target 0x0100, pointer 0x0010.
  - EQUAL with flags 001 → pointer 0x0100.
  - LARGER with flags 010 → no jump, no pulse.
  - UNEQUAL with flags 100 → jump.
- **Jump vs. advance**: DIRECT together with `i_advance` → pointer equals target exactly (not target+1).
- **Wait**:
  - WAIT 3 → stall high exactly 3 cycles.
  - `i_advance` and a DIRECT during the stall are ignored.
  - WAIT 0 → no stall.
- **Stop/resume and wrong device**:
  - STOP → halted=1, regfile_en 00, pointer frozen despite `i_advance`.
  - DIRECT → WORK with the target loaded.
  - A command to device 0x0002 → no effect.
- **Wrap and async reset**:
  - Pointer 0xFFFF + advance → 0x0000.
  - Assert `rst` between edges while in WAIT → outputs reset values immediately.
